// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 on-chip memory responder.
// Wait counts run 1..7, so the access counter fits in 3 bits.
package lc3_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_DONE = 3'd2,
    S_WR_WAIT = 3'd3,
    S_WR_DONE = 3'd4
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int MAX_WAIT = 7;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  // Counter value at which an access completes; the counter is 1 on entry.
  function automatic logic [CNT_W-1:0] last_cnt(input int wait_n);
    if (wait_n <= 1)
      return CNT_W'(1);
    return CNT_W'(wait_n - 1);
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous RAM, DEPTH x 16.
// Registered read output; contents are not reset.
module lc3_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: Mem_OE/Mem_WE handshake, decode to the
// on-chip array or the 0xFFFF I/O register, programmable latency.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int READ_WAIT = 3,
  parameter int WRITE_WAIT = 3,
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Ready,
  output logic [15:0] Hex_Out,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] RD_LAST = last_cnt(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_LAST = last_cnt(WRITE_WAIT);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      addr_l;
  logic [15:0]      data_l;

  logic             is_io;
  logic             is_arr;
  logic             rd_last;
  logic             wr_last;
  logic [15:0]      rd_val;

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [15:0]      ram_rdata;

  assign is_io   = (addr_l == IO_ADDR);
  assign is_arr  = !is_io && (32'(addr_l) < 32'(DEPTH));
  assign rd_last = (cnt == RD_LAST);
  assign wr_last = (cnt == WR_LAST);

  assign Ready = (state == S_RD_DONE) || (state == S_WR_DONE);

  // In IDLE the RAM sees the live bus so the first wait edge
  // already fetches; afterwards only the latched address matters.
  assign ram_addr = (state == S_IDLE) ? ADDR[AW-1:0]
                                      : addr_l[AW-1:0];

  assign ram_we = (state == S_WR_WAIT) && Mem_WE
                  && wr_last && is_arr;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_io:   rd_val = Switches;
      is_arr:  rd_val = ram_rdata;
      default: rd_val = '0;
    endcase
  end

  lc3_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .Clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_l),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      addr_l      <= '0;
      data_l      <= '0;
      Data_to_CPU <= '0;
      Hex_Out     <= '0;
      Err         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Mem_WE) begin
            addr_l <= ADDR;
            data_l <= Data_from_CPU;
            cnt    <= CNT_W'(1);
            state  <= S_WR_WAIT;
            if (Mem_OE)
              Err <= 1'b1;
          end else if (Mem_OE) begin
            addr_l <= ADDR;
            cnt    <= CNT_W'(1);
            state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (!Mem_OE) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (rd_last) begin
            Data_to_CPU <= rd_val;
            state       <= S_RD_DONE;
            if (!is_io && !is_arr)
              Err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RD_DONE: begin
          if (!Mem_OE) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (!Mem_WE) begin
            cnt   <= '0;
            Err   <= 1'b1;
            state <= S_IDLE;
          end else if (wr_last) begin
            state <= S_WR_DONE;
            if (is_io)
              Hex_Out <= data_l;
            else if (!is_arr)
              Err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WR_DONE: begin
          if (!Mem_WE) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder at default parameters.
// Cycle k ends at rising edge k; outputs are sampled 1 ns after an edge.
module tb_lc3_mem_responder;
  import lc3_mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] Data_from_CPU = '0;
  logic [15:0] Switches = '0;
  logic [15:0] Data_to_CPU;
  logic        Ready;
  logic [15:0] Hex_Out;
  logic        Err;

  int checks = 0;
  int errors = 0;

  lc3_mem_responder dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Switches      (Switches),
    .Data_to_CPU   (Data_to_CPU),
    .Ready         (Ready),
    .Hex_Out       (Hex_Out),
    .Err           (Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a,
                    input logic [15:0] exp,
                    input string tag);
    ADDR = a;
    Mem_OE = 1'b1;
    repeat (3) step();
    check({tag, "_rdy"}, 16'(Ready), 16'd1);
    check(tag, Data_to_CPU, exp);
    step();
    Mem_OE = 1'b0;
    step();
    check({tag, "_rdy0"}, 16'(Ready), 16'd0);
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [15:0] d,
                    input string tag);
    ADDR = a;
    Data_from_CPU = d;
    Mem_WE = 1'b1;
    repeat (3) step();
    check({tag, "_rdy"}, 16'(Ready), 16'd1);
    step();
    Mem_WE = 1'b0;
    step();
  endtask

  initial begin
    #12;
    check("rst_data", Data_to_CPU, 16'h0000);
    check("rst_rdy", 16'(Ready), 16'd0);
    check("rst_hex", Hex_Out, 16'h0000);
    check("rst_err", 16'(Err), 16'd0);
    check("rst_state", 16'(dut.state), 16'(S_IDLE));
    step();
    Reset_n = 1'b1;
    step();

    wr(16'h0010, 16'h1234, "wr10");
    check("wr10_err", 16'(Err), 16'd0);
    rd(16'h0010, 16'h1234, "rd10");

    // I/O store: Hex_Out changes only at the third edge
    ADDR = 16'hFFFF;
    Data_from_CPU = 16'hBEEF;
    Mem_WE = 1'b1;
    step();
    step();
    check("hex_pre", Hex_Out, 16'h0000);
    step();
    check("hex_post", Hex_Out, 16'hBEEF);
    check("hex_rdy", 16'(Ready), 16'd1);
    step();
    Mem_WE = 1'b0;
    step();

    Switches = 16'h00A5;
    rd(16'hFFFF, 16'h00A5, "rd_io");
    check("io_err", 16'(Err), 16'd0);

    // Early WE drop must not commit
    wr(16'h0020, 16'h7777, "wr20");
    ADDR = 16'h0020;
    Data_from_CPU = 16'hDEAD;
    Mem_WE = 1'b1;
    step();
    Mem_WE = 1'b0;
    step();
    check("abort_err", 16'(Err), 16'd1);
    check("abort_state", 16'(dut.state), 16'(S_IDLE));
    check("abort_rdy", 16'(Ready), 16'd0);
    rd(16'h0020, 16'h7777, "rd20");

    // Async reset in RD_WAIT
    ADDR = 16'h0010;
    Mem_OE = 1'b1;
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    check("mrst_state", 16'(dut.state), 16'(S_IDLE));
    check("mrst_rdy", 16'(Ready), 16'd0);
    check("mrst_data", Data_to_CPU, 16'h0000);
    check("mrst_err", 16'(Err), 16'd0);
    Mem_OE = 1'b0;
    step();
    Reset_n = 1'b1;
    step();

    // Async reset one edge before a write commit
    ADDR = 16'h0010;
    Data_from_CPU = 16'hAAAA;
    Mem_WE = 1'b1;
    step();
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    check("wrst_state", 16'(dut.state), 16'(S_IDLE));
    Mem_WE = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    rd(16'h0010, 16'h1234, "rd10_keep");

    // OE and WE together: write wins, Err set
    ADDR = 16'h0030;
    Data_from_CPU = 16'h5555;
    Mem_WE = 1'b1;
    Mem_OE = 1'b1;
    repeat (3) step();
    check("both_rdy", 16'(Ready), 16'd1);
    check("both_err", 16'(Err), 16'd1);
    step();
    Mem_WE = 1'b0;
    Mem_OE = 1'b0;
    step();
    rd(16'h0030, 16'h5555, "rd30");

    // ADDR change mid-access is ignored
    ADDR = 16'h0030;
    Mem_OE = 1'b1;
    step();
    ADDR = 16'h0010;
    step();
    step();
    check("addr_hold", Data_to_CPU, 16'h5555);
    step();
    Mem_OE = 1'b0;
    step();

    // Unmapped read after a clean reset
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    rd(16'h0010, 16'h1234, "rd10_b");
    check("pre_unmap_err", 16'(Err), 16'd0);
    rd(16'h8000, 16'h0000, "rd_unmap");
    check("unmap_err", 16'(Err), 16'd1);

    // OE held 10 cycles: one access, Ready held throughout
    ADDR = 16'h0010;
    Mem_OE = 1'b1;
    repeat (3) step();
    check("hold_c4", 16'(Ready), 16'd1);
    repeat (6) step();
    check("hold_c10", 16'(Ready), 16'd1);
    check("hold_state", 16'(dut.state), 16'(S_RD_DONE));
    check("hold_data", Data_to_CPU, 16'h1234);
    step();
    Mem_OE = 1'b0;
    step();
    check("hold_fall", 16'(Ready), 16'd0);
    check("hold_idle", 16'(dut.state), 16'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
